// File: rtl/mod3_frame_tx_pkg.sv
// Shared definitions for the mod-3 framed serial transmitter and receiver arithmetic.
package mod3_frame_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DATA = 2'b01,
        CHK1 = 2'b10,
        CHK0 = 2'b11
    } state_t;

    localparam logic [1:0] R0 = 2'b00;
    localparam logic [1:0] R1 = 2'b01;
    localparam logic [1:0] R2 = 2'b10;

endpackage

// File: rtl/mod3_frame_tx_step.sv
// Serial mod-3 residue step: r_next = (2*r + b) mod 3, MSB-first bit stream.
module mod3_step
    import mod3_frame_tx_pkg::*;
(
    input  logic [1:0] r,
    input  logic       b,
    output logic [1:0] r_next
);

    always_comb begin
        r_next = R0;
        case ({r, b})
            3'b000:  r_next = R0;
            3'b001:  r_next = R1;
            3'b010:  r_next = R2;
            3'b011:  r_next = R0;
            3'b100:  r_next = R1;
            3'b101:  r_next = R2;
            default: r_next = R0;
        endcase
    end

endmodule

// File: rtl/mod3_frame_tx.sv
// Serialises DATA_W-bit payloads MSB-first, appending two check bits that make
// each frame divisible by 3; valid/ready on both sides, back-to-back capable.
module mod3_frame_tx
    import mod3_frame_tx_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    input  logic              tx_ready,
    output logic              tx_valid,
    output logic              tx_bit,
    output logic              tx_last,
    output logic [1:0]        residue,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] payload_q, payload_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        residue_d;
    logic [1:0]        step_r;

    mod3_step u_step (
        .r      (residue),
        .b      (tx_bit),
        .r_next (step_r)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            payload_q <= '0;
            cnt_q     <= '0;
            residue   <= R0;
        end else begin
            state_q   <= state_d;
            payload_q <= payload_d;
            cnt_q     <= cnt_d;
            residue   <= residue_d;
        end
    end

    // Output decode from state and registers only; both check bits equal
    // (residue == R1), which is the same as deriving C from the CHK1-entry residue.
    always_comb begin
        tx_valid = (state_q != IDLE);
        tx_bit   = 1'b0;
        tx_last  = 1'b0;
        case (state_q)
            DATA:    tx_bit = payload_q[cnt_q];
            CHK1:    tx_bit = (residue == R1);
            CHK0: begin
                tx_bit  = (residue == R1);
                tx_last = 1'b1;
            end
            default: tx_bit = 1'b0;
        endcase
    end

    assign busy = (state_q != IDLE);

    // Next-state, counter, payload capture and residue accumulation.
    always_comb begin
        state_d    = state_q;
        payload_d  = payload_q;
        cnt_d      = cnt_q;
        residue_d  = residue;
        load_ready = 1'b0;

        if (tx_valid && tx_ready) begin
            residue_d = step_r;
        end

        case (state_q)
            IDLE: load_ready = 1'b1;
            DATA: begin
                if (tx_ready) begin
                    if (cnt_q == '0) begin
                        state_d = CHK1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            CHK1: begin
                if (tx_ready) begin
                    state_d = CHK0;
                end
            end
            CHK0: begin
                if (tx_ready) begin
                    load_ready = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_valid && load_ready) begin
            payload_d = load_data;
            residue_d = R0;
            cnt_d     = CNT_W'(DATA_W - 1);
            state_d   = DATA;
        end
    end

endmodule

// File: doc/mod3_frame_tx.md
MOD3_FRAME_TX -- requirements
Module: mod3_frame_tx

Interface
REQ-001 Parameter DATA_W, default 8, payload width in bits (DATA_W >= 2).
REQ-002 clock  input  1  rising-edge system clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 load_valid  input  1  upstream offers a payload word.
REQ-005 load_data  input  DATA_W  payload word; bit DATA_W-1 is sent first.
REQ-006 load_ready  output  1  block accepts load_data this cycle.
REQ-007 tx_ready  input  1  downstream accepts tx_bit this cycle.
REQ-008 tx_valid  output  1  tx_bit is a valid frame bit.
REQ-009 tx_bit  output  1  serial frame bit.
REQ-010 tx_last  output  1  marks the final frame bit.
REQ-011 residue  output  2  running mod-3 residue of the frame bits already transferred, with the frame read MSB-first as a binary number.
REQ-012 busy  output  1  a frame is in progress.

Function
REQ-013 Frame format: the DATA_W payload bits MSB-first, then a 2-bit check C (C[1] first), so that the full (DATA_W+2)-bit frame value is divisible by 3.
REQ-014 Check rule: with r = payload residue, C = 2'b00 for r=0, 2'b10 for r=1, 2'b01 for r=2.
REQ-015 Residue update per transferred bit b: r_next = (2*r + b) mod 3; residue never holds 2'b11.
REQ-016 The FSM has four states: IDLE, DATA, CHK1, CHK0.
REQ-017 IDLE: load_ready=1, tx_valid=0; on load_valid&load_ready, capture load_data, clear residue to 0, bit counter := DATA_W-1, go to DATA.
REQ-018 DATA: tx_valid=1, tx_bit = payload[counter]; on tx_ready, update residue and decrement counter; after the transfer at counter 0, go to CHK1.
REQ-019 CHK1: tx_valid=1, tx_bit=C[1]; C is computed from the residue at CHK1 entry; on tx_ready, go to CHK0.
REQ-020 CHK0: tx_valid=1, tx_bit=C[0], tx_last=1; on tx_ready, go to IDLE, or go to DATA if a load is accepted in the same cycle.
REQ-021 load_ready = IDLE | (CHK0 & tx_ready); this gives back-to-back frames with zero idle cycles, one frame per DATA_W+2 transfers.
REQ-022 Backpressure: when tx_valid=1 and tx_ready=0, hold tx_bit, tx_last, state, counter and residue unchanged.
REQ-023 load_valid while load_ready=0 is ignored; load_data is not sampled.
REQ-024 The first payload bit appears on tx_valid one cycle after load acceptance; latency is 1 cycle.
REQ-025 residue reads 0 after the final CHK0 transfer of every frame.
REQ-026 When tx_valid=0: tx_bit=0 and tx_last=0.
REQ-027 busy = (state != IDLE).
REQ-028 All outputs are driven from registers or from state only; no combinational path from tx_ready to tx_valid, tx_bit or tx_last.

Reset
REQ-029 Asserting reset at any time, including mid-frame, forces state IDLE, residue 0, counter 0, payload register 0, tx_valid 0, tx_bit 0, tx_last 0, busy 0, load_ready 1.
REQ-030 A partially sent frame is abandoned; no check bits are sent after reset release.
REQ-031 The first load is accepted on the first rising edge after reset deasserts.

Structure
REQ-032 A shared package holds the state encoding (IDLE=2'b00, DATA=2'b01, CHK1=2'b10, CHK0=2'b11) and the residue constants R0/R1/R2.
REQ-033 The residue-step function (r, b -> r_next) lives in one combinational sub-module, mod3_step, so the existing serial mod-3 receiver's arithmetic can share it.

Verification
REQ-034 DATA_W=8, load 8'h01, tx_ready=1 -> bits 0000000110, tx_last on bit 10, residue ends 0.
REQ-035 Load 8'h02 -> check bits 01, frame 0000001001 (value 9); load 8'hFF -> check 00.
REQ-036 Two back-to-back loads (8'h01, then 8'h02 held at load_valid) -> 20 consecutive tx_valid cycles with no gap; the second load is accepted in the CHK0 cycle of the first frame.
REQ-037 Load 8'hA5 with tx_ready toggling 1,0,0,1 repeatedly -> bit stream identical to the unstalled case; outputs stable during stalls.
REQ-038 Reset asserted at payload bit 4 -> all outputs take reset values asynchronously; next load 8'h03 sends 0000001100.
REQ-039 Loopback into the existing serial mod-3 receiver, 256 payloads 8'h00-8'hFF -> receiver reports residue 0 after every frame.
